// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one single-port TCDM bank between NumIn requesters.
// Reads return through a per-port 1-entry response slot; writes complete on grant.
module tcdm_bank_arbiter #(
  parameter int unsigned NumIn     = 5,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth  = 16,
  localparam int unsigned BeWidth  = DataWidth / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumIn-1:0]               req_valid_i,
  output logic [NumIn-1:0]               req_ready_o,
  input  logic [NumIn*AddrWidth-1:0]     req_addr_i,
  input  logic [NumIn-1:0]               req_wen_i,
  input  logic [NumIn*BeWidth-1:0]       req_be_i,
  input  logic [NumIn*DataWidth-1:0]     req_wdata_i,
  output logic [NumIn-1:0]               resp_valid_o,
  input  logic [NumIn-1:0]               resp_ready_i,
  output logic [NumIn*DataWidth-1:0]     resp_rdata_o,
  output logic                           mem_req_o,
  output logic                           mem_wen_o,
  output logic [AddrWidth-1:0]           mem_addr_o,
  output logic [BeWidth-1:0]             mem_be_o,
  output logic [DataWidth-1:0]           mem_wdata_o,
  input  logic [DataWidth-1:0]           mem_rdata_i,
  output logic [CntWidth-1:0]            conflicts_o
);

  localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
  typedef logic [IdxW-1:0] idx_t;

  idx_t                            rr_ptr_q, rr_ptr_d;
  idx_t                            pend_idx_q, pend_idx_d;
  idx_t                            gnt_idx;
  logic                            pend_q, pend_d;
  logic                            gnt_valid, seen, multi;
  logic [NumIn-1:0]                eligible, slot_free;
  logic [NumIn-1:0]                resp_valid_q, resp_valid_d;
  logic [NumIn-1:0][DataWidth-1:0] resp_rdata_q, resp_rdata_d;
  logic [CntWidth-1:0]             conflicts_q, conflicts_d;

  // Two passes implement the wrap-around scan: ports at/after the pointer first, then the rest.
  always_comb begin
    eligible  = '0;
    slot_free = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    seen      = 1'b0;
    multi     = 1'b0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      slot_free[i] = ~(pend_q & (pend_idx_q == idx_t'(i))) & (~resp_valid_q[i] | resp_ready_i[i]);
      eligible[i]  = req_valid_i[i] & (req_wen_i[i] | slot_free[i]);
      if (eligible[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NumIn; i++) begin
      if (!gnt_valid && eligible[i] && (idx_t'(i) >= rr_ptr_q)) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx_t'(i);
      end
    end
    for (int unsigned i = 0; i < NumIn; i++) begin
      if (!gnt_valid && eligible[i] && (idx_t'(i) < rr_ptr_q)) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx_t'(i);
      end
    end
    gnt_valid = gnt_valid & rst_ni;
  end

  always_comb begin
    req_ready_o = '0;
    mem_req_o   = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (gnt_valid) begin
      req_ready_o[gnt_idx] = 1'b1;
      mem_req_o            = 1'b1;
      mem_wen_o            = req_wen_i[gnt_idx];
      mem_addr_o           = req_addr_i[gnt_idx*AddrWidth +: AddrWidth];
      mem_be_o             = req_be_i[gnt_idx*BeWidth +: BeWidth];
      mem_wdata_o          = req_wdata_i[gnt_idx*DataWidth +: DataWidth];
    end
  end

  // A slot reload from the bank takes priority over the same-edge drain.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid) begin
      rr_ptr_d = (gnt_idx == idx_t'(NumIn - 1)) ? '0 : gnt_idx + idx_t'(1);
    end
    pend_d       = gnt_valid & ~req_wen_i[gnt_idx];
    pend_idx_d   = pend_d ? gnt_idx : pend_idx_q;
    resp_valid_d = resp_valid_q & ~resp_ready_i;
    resp_rdata_d = resp_rdata_q;
    if (pend_q) begin
      resp_valid_d[pend_idx_q] = 1'b1;
      resp_rdata_d[pend_idx_q] = mem_rdata_i;
    end
    conflicts_d = (multi && (conflicts_q != '1)) ? conflicts_q + CntWidth'(1) : conflicts_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      pend_q       <= 1'b0;
      pend_idx_q   <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      conflicts_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      pend_q       <= pend_d;
      pend_idx_q   <= pend_idx_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      conflicts_q  <= conflicts_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign conflicts_o  = conflicts_q;

endmodule
